regfile_wb_arbiter: RTL and testbench

- Write-back controller for the scalar register file. It shares the file's single write port (regWrEnScalar/regToWrite/dataIn) between numReq producers, for example the ALU, the load unit and the vector-reduce path.
- Arbitration is round-robin with a valid/ready handshake. The write is registered, so it reaches the register file one cycle after it is accepted.
- A busy-bit scoreboard tracks registers that have a write outstanding. The block raises stall to the decode stage when a source operand is still pending.

---
 rtl/regfile_ctrl_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 57 +++++
 rtl/regfile_wb_arbiter.sv | 110 +++++++++++
 tb/tb_regfile_wb_arbiter.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_ctrl_pkg.sv
// ============================================================================
// Module      : regfile_ctrl_pkg
// Description : Shared constants and types for the scalar register-file control.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package regfile_ctrl_pkg;

    localparam int REG_SIZE   = 128;
    localparam int REG_QTY    = 4;
    localparam int SEL_BITS   = 2;
    localparam int NUM_WB_REQ = 3;

    typedef logic [SEL_BITS-1:0] reg_sel_t;
    typedef logic [REG_SIZE-1:0] reg_data_t;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// Module      : rr_arbiter
// Description : Round-robin arbiter; pointer advances past the winner on a transfer.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module rr_arbiter
    import regfile_ctrl_pkg::*;
#(
    parameter int N     = NUM_WB_REQ,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     req,
    input  logic             advance,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grantIdx
);

    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] w_idx;
    logic             w_found;
    logic [IDX_W-1:0] w_ptr_nxt;

    always_comb begin
        int j;
        w_found = 1'b0;
        w_idx   = '0;
        j       = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(r_ptr) + k) % N;
            if (!w_found && req[j]) begin
                w_found = 1'b1;
                w_idx   = IDX_W'(j);
            end
        end
    end

    // Grant is forced low while reset is held, independent of the pointer.
    assign grant    = (w_found && reset) ? (N'(1) << w_idx) : '0;
    assign grantIdx = w_idx;

    assign w_ptr_nxt = (w_idx == IDX_W'(N - 1)) ? '0 : (w_idx + 1'b1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ptr <= '0;
        end else if (advance) begin
            r_ptr <= w_ptr_nxt;
        end
    end

endmodule

`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
// ============================================================================
// Module      : regfile_wb_arbiter
// Description : Register-file write-back arbiter with busy-bit scoreboard and stall.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module regfile_wb_arbiter
    import regfile_ctrl_pkg::*;
#(
    parameter int regSize     = REG_SIZE,
    parameter int regQuantity = REG_QTY,
    parameter int selBits     = SEL_BITS,
    parameter int numReq      = NUM_WB_REQ
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [numReq-1:0]           reqValid,
    input  logic [numReq*selBits-1:0]   reqReg,
    input  logic [numReq*regSize-1:0]   reqData,
    output logic [numReq-1:0]           reqReady,
    input  logic                        claimValid,
    input  logic [selBits-1:0]          claimReg,
    input  logic [selBits-1:0]          rSel1,
    input  logic [selBits-1:0]          rSel2,
    input  logic                        rdUse1,
    input  logic                        rdUse2,
    output logic                        stall,
    output logic                        regWrEnScalar,
    output logic [selBits-1:0]          regToWrite,
    output logic [regSize-1:0]          dataIn,
    output logic [regQuantity-1:0]      busyMask
);

    localparam int IDX_W = (numReq > 1) ? $clog2(numReq) : 1;

    logic [numReq-1:0]      w_grant;
    logic [IDX_W-1:0]       w_gidx;
    logic                   w_xfer;
    logic                   r_wr_en;
    logic [selBits-1:0]     r_wr_reg;
    logic [regSize-1:0]     r_wr_data;
    logic [regQuantity-1:0] r_busy;
    logic [regQuantity-1:0] w_busy_nxt;

    rr_arbiter #(
        .N     (numReq),
        .IDX_W (IDX_W)
    ) u_arb (
        .clk      (clk),
        .reset    (reset),
        .req      (reqValid),
        .advance  (w_xfer),
        .grant    (w_grant),
        .grantIdx (w_gidx)
    );

    assign reqReady = w_grant;
    assign w_xfer   = |(reqValid & w_grant);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_en   <= 1'b0;
            r_wr_reg  <= '0;
            r_wr_data <= '0;
        end else begin
            r_wr_en <= w_xfer;
            if (w_xfer) begin
                r_wr_reg  <= reqReg[int'(w_gidx)*selBits +: selBits];
                r_wr_data <= reqData[int'(w_gidx)*regSize +: regSize];
            end
        end
    end

    // A claim outranks a same-cycle commit: it belongs to a newer writer.
    always_comb begin
        w_busy_nxt = r_busy;
        for (int r = 0; r < regQuantity; r++) begin
            if (claimValid && (claimReg == selBits'(r))) begin
                w_busy_nxt[r] = 1'b1;
            end else if (r_wr_en && (r_wr_reg == selBits'(r))) begin
                w_busy_nxt[r] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    assign stall         = (rdUse1 & r_busy[rSel1]) | (rdUse2 & r_busy[rSel2]);
    assign regWrEnScalar = r_wr_en;
    assign regToWrite    = r_wr_reg;
    assign dataIn        = r_wr_data;
    assign busyMask      = r_busy;

    a_no_claim_on_stall : assert property (@(posedge clk) disable iff (!reset)
        !(claimValid && stall));

    // Re-claiming is legal only in the cycle the previous writer commits.
    a_no_waw : assert property (@(posedge clk) disable iff (!reset)
        !(claimValid && r_busy[claimReg] && !(r_wr_en && (r_wr_reg == claimReg))));

endmodule

`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
// ============================================================================
// Module      : tb_regfile_wb_arbiter
// Description : Scoreboard bench for regfile_wb_arbiter against a behavioural model.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_regfile_wb_arbiter;
    import regfile_ctrl_pkg::*;

    localparam int NR = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic [NR-1:0]     reqValid;
    logic [NR*2-1:0]   reqReg;
    logic [NR*128-1:0] reqData;
    logic [NR-1:0]     reqReady;
    logic              claimValid;
    reg_sel_t          claimReg;
    reg_sel_t          rSel1, rSel2;
    logic              rdUse1, rdUse2;
    logic              stall;
    logic              regWrEnScalar;
    reg_sel_t          regToWrite;
    reg_data_t         dataIn;
    logic [3:0]        busyMask;

    regfile_wb_arbiter dut (
        .clk(clk), .reset(reset), .reqValid(reqValid), .reqReg(reqReg),
        .reqData(reqData), .reqReady(reqReady), .claimValid(claimValid),
        .claimReg(claimReg), .rSel1(rSel1), .rSel2(rSel2), .rdUse1(rdUse1),
        .rdUse2(rdUse2), .stall(stall), .regWrEnScalar(regWrEnScalar),
        .regToWrite(regToWrite), .dataIn(dataIn), .busyMask(busyMask)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]   r;
        logic [127:0] d;
        int           due;
    } wb_t;

    wb_t        q[$];
    int         checks   = 0;
    int         failures = 0;
    int         cyc      = 0;
    int         m_ptr    = 0;
    logic [3:0] m_busy   = '0;
    logic       m_pend_v = 1'b0;
    logic [1:0] m_pend_r = '0;
    logic [2:0] m_acc    = '0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: round-robin from a pointer, busy bits set by claims, cleared by commits.
    always @(negedge clk) begin
        if (!reset) begin
            chk("rst_ready", 128'(reqReady), 128'(0));
            chk("rst_stall", 128'(stall), 128'(0));
            chk("rst_busy", 128'(busyMask), 128'(0));
            chk("rst_wren", 128'(regWrEnScalar), 128'(0));
            m_ptr = 0; m_busy = '0; m_pend_v = 1'b0; m_acc = '0;
            q.delete();
        end else begin
            int g;
            logic [2:0] exp_ready;
            logic exp_stall;
            g = -1;
            for (int k = 0; k < NR; k++) begin
                int i;
                i = (m_ptr + k) % NR;
                if (g < 0 && reqValid[i]) g = i;
            end
            exp_ready = (g >= 0) ? 3'(1 << g) : 3'b000;
            exp_stall = (rdUse1 && m_busy[rSel1]) || (rdUse2 && m_busy[rSel2]);
            chk("reqReady", 128'(reqReady), 128'(exp_ready));
            chk("stall", 128'(stall), 128'(exp_stall));
            chk("busyMask", 128'(busyMask), 128'(m_busy));
            m_acc = exp_ready;
            if (m_pend_v) m_busy[m_pend_r] = 1'b0;
            if (claimValid) m_busy[claimReg] = 1'b1;
            m_pend_v = 1'b0;
            if (g >= 0) begin
                wb_t e;
                e.r = reqReg[g*2 +: 2];
                e.d = reqData[g*128 +: 128];
                e.due = cyc + 1;
                q.push_back(e);
                m_pend_v = 1'b1;
                m_pend_r = e.r;
                m_ptr = (g + 1) % NR;
            end
        end
    end

    // Monitor: every write-enable pulse must match the oldest accepted request.
    always @(negedge clk) begin
        if (reset && regWrEnScalar) begin
            if (q.size() == 0) begin
                chk("unexpected_write", 128'(1), 128'(0));
            end else begin
                wb_t e;
                e = q.pop_front();
                chk("regToWrite", 128'(regToWrite), 128'(e.r));
                chk("dataIn", dataIn, e.d);
                chk("write_latency", 128'(cyc), 128'(e.due));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reqValid = '0; claimValid = 1'b0; claimReg = '0;
        rSel1 = '0; rSel2 = '0; rdUse1 = 1'b0; rdUse2 = 1'b0;
    endtask

    task automatic set_req(input int i, input logic [1:0] r, input logic [127:0] d);
        reqValid[i] = 1'b1;
        reqReg[i*2 +: 2] = r;
        reqData[i*128 +: 128] = d;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        reset = 1'b0;
        reqReg = '0; reqData = '0;
        idle();
        for (int c = 0; c < 4; c++) begin
            reqValid = 3'($urandom); reqReg = 6'($urandom);
            claimValid = 1'($urandom); claimReg = 2'($urandom);
            rSel1 = 2'($urandom); rSel2 = 2'($urandom);
            rdUse1 = 1'($urandom); rdUse2 = 1'($urandom);
            step();
        end
        idle();
        reset = 1'b1;
        step();

        set_req(0, 2'd2, {16{8'hA5}});
        step();
        reqValid = '0;
        step(); step();

        for (int i = 0; i < NR; i++) set_req(i, 2'($urandom), rnd128());
        for (int c = 0; c < 6; c++) begin
            step();
            for (int i = 0; i < NR; i++)
                if (m_acc[i]) set_req(i, 2'($urandom), rnd128());
        end
        reqValid = '0;
        step(); step();

        claimValid = 1'b1; claimReg = 2'd1;
        step();
        claimValid = 1'b0; rSel1 = 2'd1; rdUse1 = 1'b1;
        step(); step(); step();
        set_req(0, 2'd1, rnd128());
        step();
        reqValid = '0;
        step(); step();
        rdUse1 = 1'b0;

        claimValid = 1'b1; claimReg = 2'd3;
        step();
        claimValid = 1'b0;
        set_req(1, 2'd3, rnd128());
        step();
        reqValid = '0; claimValid = 1'b1; claimReg = 2'd3;
        step();
        claimValid = 1'b0;
        step();
        set_req(2, 2'd3, rnd128());
        step();
        reqValid = '0;
        step(); step();

        claimValid = 1'b1; claimReg = 2'd0;
        step();
        claimValid = 1'b0; rSel2 = 2'd0; rdUse2 = 1'b0; rSel1 = 2'd0; rdUse1 = 1'b0;
        step();
        set_req(0, 2'd0, rnd128());
        step();
        reqValid = '0;
        step(); step();

        reqValid = '0;
        step(); step();
        set_req(1, 2'd2, rnd128());
        #2 reset = 1'b0;
        step(); step();
        idle();
        reset = 1'b1;
        step();
        for (int i = 0; i < NR; i++) set_req(i, 2'($urandom), rnd128());
        step();
        reqValid = '0;
        step(); step();

        for (int c = 0; c < 400; c++) begin
            logic s;
            for (int i = 0; i < NR; i++)
                if (!reqValid[i] || m_acc[i]) begin
                    reqValid[i] = 1'($urandom);
                    reqReg[i*2 +: 2] = 2'($urandom);
                    reqData[i*128 +: 128] = rnd128();
                end
            rSel1 = 2'($urandom); rSel2 = 2'($urandom);
            rdUse1 = 1'($urandom); rdUse2 = 1'($urandom);
            s = (rdUse1 && m_busy[rSel1]) || (rdUse2 && m_busy[rSel2]);
            claimValid = 1'b0;
            if (!s && ($urandom % 3 == 0)) begin
                logic [1:0] r;
                r = 2'($urandom);
                if (!m_busy[r]) begin
                    claimValid = 1'b1;
                    claimReg = r;
                end
            end
            step();
        end

        idle();
        step(); step(); step();
        chk("queue_drained", 128'(q.size()), 128'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
